// File: rtl/mdu_ctrl.sv
// mdu_ctrl - multi-cycle multiply/divide controller for the execute stage.
//
// One MD operation is accepted at a time. Its full result is computed into
// shadow registers at the start edge. The block then stays busy for a fixed
// latency and commits the shadow result to the architectural HI/LO registers
// in one edge. The pipeline therefore never sees a partial HI/LO update.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (md_op 7..10), which accumulate into {HI,LO}.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   request strobe from EX, sampled on the rising edge
//   md_op      in   4-bit operation code (see OP_* below)
//   a, b       in   rs / rt operands
//   rd_sel     in   read select for rdata: 0 LO, 1 HI
//   busy       out  an operation is in flight
//   stall_req  out  stall request to the hazard unit (combinational)
//   rdata      out  rd_sel ? hi : lo (combinational)
//   hi, lo     out  architectural HI / LO
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    // Counter reload values: busy lasts N cycles, so the counter runs N-1..0.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True for every opcode that occupies the unit for more than one cycle.
    function automatic logic is_multi_op(input logic [3:0] op);
        logic res;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: res = 1'b1;
`endif
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic [31:0] hi_r, hi_nxt_s, lo_r, lo_nxt_s;
    logic [31:0] shadow_hi_r, shadow_hi_nxt_s, shadow_lo_r, shadow_lo_nxt_s;
    logic        commit_r, commit_nxt_s;

    logic [63:0] mul_a_s, mul_b_s, prod_s, result_s;
    logic        result_commit_s;
    logic        div_signed_s, a_neg_s, b_neg_s;
    logic [31:0] mag_a_s, mag_b_s, den_s, q_mag_s, r_mag_s, quot_s, rem_s;

    // Datapath: product, sign-magnitude division and result selection.
    always_comb begin
        mul_a_s = {32'd0, a};
        mul_b_s = {32'd0, b};
        if (md_op == OP_MULT || md_op == OP_MADD || md_op == OP_MSUB) begin
            mul_a_s = {{32{a[31]}}, a};
            mul_b_s = {{32{b[31]}}, b};
        end else begin
            mul_a_s = {32'd0, a};
            mul_b_s = {32'd0, b};
        end
        prod_s = mul_a_s * mul_b_s;

        // Divide magnitudes unsigned, then restore signs. This truncates
        // toward zero, gives the remainder the dividend's sign, and makes
        // 0x80000000 / -1 wrap to 0x80000000 remainder 0 without a special case.
        div_signed_s = (md_op == OP_DIV);
        a_neg_s      = div_signed_s & a[31];
        b_neg_s      = div_signed_s & b[31];
        mag_a_s      = a_neg_s ? (32'd0 - a) : a;
        mag_b_s      = b_neg_s ? (32'd0 - b) : b;
        // A zero divisor is replaced so the divider never sees it; that result is never committed.
        den_s        = (b == 32'd0) ? 32'd1 : mag_b_s;
        q_mag_s      = mag_a_s / den_s;
        r_mag_s      = mag_a_s % den_s;
        quot_s       = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s        = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;

        result_s        = {hi_r, lo_r};
        result_commit_s = 1'b0;
        case (md_op)
            OP_MULT, OP_MULTU: begin
                result_s        = prod_s;
                result_commit_s = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                result_s        = {rem_s, quot_s};
                result_commit_s = (b != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                result_s        = {hi_r, lo_r} + prod_s;
                result_commit_s = 1'b1;
            end
            OP_MSUB, OP_MSUBU: begin
                result_s        = {hi_r, lo_r} - prod_s;
                result_commit_s = 1'b1;
            end
`endif
            default: begin
                result_s        = {hi_r, lo_r};
                result_commit_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: accept in IDLE, count down in RUN, commit on zero.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        hi_nxt_s        = hi_r;
        lo_nxt_s        = lo_r;
        shadow_hi_nxt_s = shadow_hi_r;
        shadow_lo_nxt_s = shadow_lo_r;
        commit_nxt_s    = commit_r;
        case (state_r)
            ST_IDLE: begin
                if (start && is_multi_op(md_op)) begin
                    state_nxt_s     = ST_RUN;
                    cnt_nxt_s       = (md_op == OP_DIV || md_op == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
                    shadow_hi_nxt_s = result_s[63:32];
                    shadow_lo_nxt_s = result_s[31:0];
                    commit_nxt_s    = result_commit_s;
                end else if (start && md_op == OP_MTHI) begin
                    hi_nxt_s = a;
                end else if (start && md_op == OP_MTLO) begin
                    lo_nxt_s = a;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Any start arriving here is dropped; stall_req holds EX.
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_IDLE;
                    if (commit_r) begin
                        hi_nxt_s = shadow_hi_r;
                        lo_nxt_s = shadow_lo_r;
                    end else begin
                        hi_nxt_s = hi_r;
                        lo_nxt_s = lo_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, architectural and shadow registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            shadow_hi_r <= 32'd0;
            shadow_lo_r <= 32'd0;
            commit_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            hi_r        <= hi_nxt_s;
            lo_r        <= lo_nxt_s;
            shadow_hi_r <= shadow_hi_nxt_s;
            shadow_lo_r <= shadow_lo_nxt_s;
            commit_r    <= commit_nxt_s;
        end
    end

    assign busy      = (state_r == ST_RUN);
    // Covers the issuing cycle too, so a dependent MFHI/MFLO behind it waits.
    assign stall_req = busy | (start & is_multi_op(md_op));
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign rdata     = rd_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl - directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a, b;
    logic        rd_sel;
    logic        busy, stall_req;
    logic [31:0] rdata, hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .rd_sel(rd_sel), .busy(busy), .stall_req(stall_req), .rdata(rdata),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one edge; report stall_req in the issuing cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output logic stall_seen);
        start = 1'b1; md_op = op; a = av; b = bv;
        #1;
        stall_seen = stall_req;
        tick();
        start = 1'b0; md_op = 4'd0; a = 32'd0; b = 32'd0;
    endtask

    // Count busy / stall cycles until busy falls (bounded); track HI/LO holding.
    task automatic run_out(input logic [31:0] h0, input logic [31:0] l0,
                           output int busy_n, output int stall_n, output logic held);
        busy_n = 0; stall_n = 0; held = 1'b1;
        while (busy === 1'b1 && busy_n < 40) begin
            busy_n++;
            if (stall_req === 1'b1) stall_n++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; md_op = 4'd0; a = 32'd0; b = 32'd0; rd_sel = 1'b0;
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall_req); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %0b want 0", busy); end
    endtask

    task automatic test_mult();
        logic s; int bn, sn; logic held;
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        issue(4'd1, 32'hFFFFFFFE, 32'h00000003, s);
        n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL mult_issue_stall: got %0b want 1", s); end
        run_out(h0, l0, bn, sn, held);
        n_checks++; if (bn != 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 5", bn); end
        n_checks++; if (sn != 5) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d want 5", sn); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL mult_hold: HI/LO changed during RUN"); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
        rd_sel = 1'b1; #1;
        n_checks++; if (rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_rdata_hi: got %h want ffffffff", rdata); end
        rd_sel = 1'b0; #1;
        n_checks++; if (rdata !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_rdata_lo: got %h want fffffffa", rdata); end
    endtask

    // Three divides issued back to back, each in the cycle the previous one's busy falls.
    task automatic test_back_to_back_div();
        logic s; int bn, sn; logic held;
        issue(4'd4, 32'd100, 32'd7, s);
        n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL divu_issue_stall: got %0b want 1", s); end
        run_out(32'hFFFFFFFF, 32'hFFFFFFFA, bn, sn, held);
        n_checks++; if (bn != 10) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d want 10", bn); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL divu_hold: HI/LO changed during RUN"); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want 00000002", hi); end
        issue(4'd3, 32'hFFFFFFF9, 32'd2, s);
        run_out(32'd2, 32'd14, bn, sn, held);
        n_checks++; if (bn != 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 10", bn); end
        n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, s);
        run_out(32'hFFFFFFFF, 32'hFFFFFFFD, bn, sn, held);
        n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_div_zero();
        logic s; int bn, sn; logic held;
        do_reset();
        issue(4'd6, 32'h12345678, 32'd0, s);
        n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL mtlo_stall: got %0b want 0", s); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %0b want 0", busy); end
        n_checks++; if (lo !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_lo: got %h want 12345678", lo); end
        rd_sel = 1'b0;
        issue(4'd3, 32'd55, 32'd0, s);
        n_checks++; if (rdata !== 32'h12345678) begin n_fail++; $display("FAIL div0_rdata_run: got %h want 12345678", rdata); end
        run_out(32'd0, 32'h12345678, bn, sn, held);
        n_checks++; if (bn != 10) begin n_fail++; $display("FAIL div0_busy_cycles: got %0d want 10", bn); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL div0_hold: HI/LO changed during RUN"); end
        n_checks++; if (lo !== 32'h12345678) begin n_fail++; $display("FAIL div0_lo: got %h want 12345678", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL div0_hi: got %h want 00000000", hi); end
        n_checks++; if (rdata !== 32'h12345678) begin n_fail++; $display("FAIL div0_rdata_end: got %h want 12345678", rdata); end
    endtask

    task automatic test_reset_mid_run();
        logic s; logic clean;
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, s);
        tick();
        reset = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL midrst_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL midrst_lo: got %h want 0", lo); end
        tick();
        reset = 1'b1;
        clean = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) clean = 1'b0;
        end
        n_checks++; if (clean !== 1'b1) begin n_fail++; $display("FAIL midrst_no_commit: hi=%h lo=%h busy=%0b want 0 0 0", hi, lo, busy); end
    endtask

    task automatic test_ignore_in_run();
        logic s; int bn, sn; logic held;
        issue(4'd1, 32'd2, 32'd3, s);
        tick();
        start = 1'b1; md_op = 4'd5; a = 32'hDEADBEEF; #1;
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL ignore_stall: got %0b want 1", stall_req); end
        tick();
        start = 1'b0; md_op = 4'd0; a = 32'd0;
        run_out(32'd0, 32'd0, bn, sn, held);
        n_checks++; if (bn != 3) begin n_fail++; $display("FAIL ignore_busy_left: got %0d want 3", bn); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL ignore_hold: HI/LO changed during RUN"); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ignore_hi: got %h want 00000000", hi); end
        n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL ignore_lo: got %h want 00000006", lo); end
    endtask

    task automatic test_reserved();
        logic s;
        issue(4'd11, 32'hFFFF0000, 32'd1, s);
        n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL rsvd_stall: got %0b want 0", s); end
        n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
            n_fail++; $display("FAIL rsvd_state: busy=%0b hi=%h lo=%h want 0 0 6", busy, hi, lo); end
        issue(4'd0, 32'hFFFF0000, 32'd1, s);
        n_checks++; if (s !== 1'b0 || busy !== 1'b0 || lo !== 32'd6) begin
            n_fail++; $display("FAIL none_op: stall=%0b busy=%0b lo=%h want 0 0 6", s, busy, lo); end
    endtask

    task automatic test_madd();
        logic s; int bn, sn; logic held;
        issue(4'd6, 32'd10, 32'd0, s);
        issue(4'd7, 32'd3, 32'd4, s);
`ifdef MDU_MADD_EN
        n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL madd_stall: got %0b want 1", s); end
        run_out(32'd0, 32'd10, bn, sn, held);
        n_checks++; if (bn != 5) begin n_fail++; $display("FAIL madd_busy_cycles: got %0d want 5", bn); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL madd_hold: HI/LO changed during RUN"); end
        n_checks++; if (lo !== 32'd22 || hi !== 32'd0) begin
            n_fail++; $display("FAIL madd_result: hi=%h lo=%h want 00000000 00000016", hi, lo); end
        issue(4'd9, 32'd5, 32'd10, s);
        run_out(32'd0, 32'd22, bn, sn, held);
        n_checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFE4) begin
            n_fail++; $display("FAIL msub_result: hi=%h lo=%h want ffffffff ffffffe4", hi, lo); end
`else
        n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL madd_off_stall: got %0b want 0", s); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL madd_off_busy: got %0b want 0", busy); end
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (lo !== 32'd10 || hi !== 32'd0) begin
            n_fail++; $display("FAIL madd_off_result: hi=%h lo=%h want 00000000 0000000a", hi, lo); end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back_div();
        test_div_zero();
        test_reset_mid_run();
        test_ignore_in_run();
        test_reserved();
        test_madd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
